// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO slice.
// Mode selectors, pointer/count width helper and the registered status-flag bundle.
package sync_fifo_pkg;

    localparam int STD_MODE  = 0;
    localparam int FWFT_MODE = 1;

    // Pointers carry one extra bit so a full buffer (equal address, differing MSB)
    // is distinguishable from an empty one; the occupancy count uses the same width.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake, data and status bundle between a FIFO and its user.
// The user side drives requests through 'master'; the FIFO answers through 'slave'.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int CNT_W = ptr_width(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous read with read-enable.
// Neither the array nor the read register is reset, so it maps onto block RAM.
module sync_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky error bits
// and an optional first-word-fall-through output stage built on the RAM read register.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = STD_MODE
) (
    input  logic      clk,
    input  logic      rst,
    sync_fifo_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ptr_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    fifo_flags_t      flags_q, flags_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_valid_q, rd_valid_d;
    logic             data_seen_q, data_seen_d;

    logic             wr_acc;
    logic             rd_acc;
    logic             ram_nonempty;
    logic             ram_rd_en;
    logic             empty_d;
    logic             rd_valid_next;
    logic [WIDTH-1:0] ram_rd_data;

    // Acceptance uses the flags registered before the edge, so a read never frees
    // room for a write in the same cycle.
    assign wr_acc       = bus.wr_en & ~flags_q.full;
    assign rd_acc       = bus.rd_en & ~flags_q.empty;
    assign ram_nonempty = (wr_ptr_q != rd_ptr_q);

    generate
        if (FWFT == FWFT_MODE) begin : g_fwft
            logic out_valid_q, out_valid_d;

            // The RAM read register is the output stage: refill it whenever it is
            // empty or being popped, as long as the RAM still holds a word.
            always_comb begin
                ram_rd_en   = (~out_valid_q | rd_acc) & ram_nonempty;
                out_valid_d = ram_rd_en | (out_valid_q & ~rd_acc);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= out_valid_d;
                end
            end

            assign empty_d       = ~out_valid_d;
            assign rd_valid_next = out_valid_d;
        end else begin : g_std
            assign ram_rd_en     = rd_acc;
            assign empty_d       = (count_d == '0);
            assign rd_valid_next = rd_acc;
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(ram_rd_en);
        count_d  = count_q + PTR_W'(wr_acc) - PTR_W'(rd_acc);

        flags_d              = FLAGS_RESET;
        flags_d.full         = (count_d == PTR_W'(DEPTH));
        flags_d.empty        = empty_d;
        flags_d.almost_full  = (count_d >= PTR_W'(AF_LEVEL));
        flags_d.almost_empty = (count_d <= PTR_W'(AE_LEVEL));

        // A new error in the same cycle as clr_err keeps the sticky bit set.
        overflow_d  = (bus.wr_en & flags_q.full)  | (overflow_q  & ~bus.clr_err);
        underflow_d = (bus.rd_en & flags_q.empty) | (underflow_q & ~bus.clr_err);

        rd_valid_d  = rd_valid_next;
        data_seen_d = data_seen_q | ram_rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            flags_q     <= FLAGS_RESET;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            data_seen_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            flags_q     <= flags_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
            data_seen_q <= data_seen_d;
        end
    end

    sync_fifo_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc & ~rst),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (bus.wr_data),
        .rd_en   (ram_rd_en & ~rst),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

    // The RAM read register is not reset; mask it until the first read after reset.
    assign bus.rd_data      = data_seen_q ? ram_rd_data : '0;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = flags_q.full;
    assign bus.empty        = flags_q.empty;
    assign bus.almost_full  = flags_q.almost_full;
    assign bus.almost_empty = flags_q.almost_empty;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one standard-read instance and one FWFT instance
// sharing clock and reset, checked with immediate assertions.
module tb_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wv;
    int   rv;

    always #5 clk = ~clk;

    sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_std ();
    sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_fwft ();

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(DEPTH - 4), .AE_LEVEL(4), .FWFT(0)) u_std (
        .clk (clk),
        .rst (rst),
        .bus (if_std)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(DEPTH - 4), .AE_LEVEL(4), .FWFT(1)) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (if_fwft)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if_std.wr_en   = 1'b0; if_std.wr_data  = '0; if_std.rd_en  = 1'b0; if_std.clr_err  = 1'b0;
        if_fwft.wr_en  = 1'b0; if_fwft.wr_data = '0; if_fwft.rd_en = 1'b0; if_fwft.clr_err = 1'b0;
        rst = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_count",    32'(if_std.count), 32'd0);
        chk("rst_empty",    32'(if_std.empty), 32'd1);
        chk("rst_ae",       32'(if_std.almost_empty), 32'd1);
        chk("rst_full",     32'(if_std.full), 32'd0);
        chk("rst_af",       32'(if_std.almost_full), 32'd0);
        chk("rst_rd_data",  32'(if_std.rd_data), 32'd0);
        chk("rst_rd_valid", 32'(if_std.rd_valid), 32'd0);
        chk("rst_ovf",      32'(if_std.overflow), 32'd0);
        chk("rst_unf",      32'(if_std.underflow), 32'd0);
        chk("rst_fwft_empty", 32'(if_fwft.empty), 32'd1);
        chk("rst_fwft_count", 32'(if_fwft.count), 32'd0);
        rst = 1'b0;
        step();

        // Fill to full: almost_full from 28, full at 32, almost_empty up to 4
        for (int i = 0; i < DEPTH; i++) begin
            if_std.wr_en   = 1'b1;
            if_std.wr_data = 8'(i);
            step();
            chk("fill_count", 32'(if_std.count), 32'(i + 1));
            chk("fill_empty", 32'(if_std.empty), 32'd0);
            chk("fill_af",    32'(if_std.almost_full), 32'(i + 1 >= 28));
            chk("fill_ae",    32'(if_std.almost_empty), 32'(i + 1 <= 4));
            chk("fill_full",  32'(if_std.full), 32'(i + 1 == DEPTH));
        end
        if_std.wr_data = 8'h20;
        step();
        chk("ovf_set",   32'(if_std.overflow), 32'd1);
        chk("ovf_count", 32'(if_std.count), 32'd32);
        chk("ovf_full",  32'(if_std.full), 32'd1);
        if_std.wr_en = 1'b0;

        // Drain in order, then one read too many
        for (int i = 0; i < DEPTH; i++) begin
            if_std.rd_en = 1'b1;
            step();
            chk("drain_data",  32'(if_std.rd_data), 32'(i));
            chk("drain_valid", 32'(if_std.rd_valid), 32'd1);
            chk("drain_count", 32'(if_std.count), 32'(DEPTH - 1 - i));
        end
        step();
        chk("unf_set",   32'(if_std.underflow), 32'd1);
        chk("unf_hold",  32'(if_std.rd_data), 32'h1F);
        chk("unf_valid", 32'(if_std.rd_valid), 32'd0);
        chk("unf_empty", 32'(if_std.empty), 32'd1);
        if_std.rd_en = 1'b0;
        step();
        chk("idle_hold", 32'(if_std.rd_data), 32'h1F);
        chk("ovf_sticky", 32'(if_std.overflow), 32'd1);
        if_std.clr_err = 1'b1;
        step();
        chk("clr_ovf", 32'(if_std.overflow), 32'd0);
        chk("clr_unf", 32'(if_std.underflow), 32'd0);
        if_std.clr_err = 1'b0;

        // Half full, then simultaneous read/write across pointer wrap
        wv = 0;
        rv = 0;
        for (int k = 0; k < 16; k++) begin
            if_std.wr_en   = 1'b1;
            if_std.wr_data = 8'(wv);
            wv++;
            step();
        end
        chk("half_count", 32'(if_std.count), 32'd16);
        for (int k = 0; k < 100; k++) begin
            if_std.wr_en   = 1'b1;
            if_std.rd_en   = 1'b1;
            if_std.wr_data = 8'(wv);
            wv++;
            step();
            chk("wrap_count", 32'(if_std.count), 32'd16);
            chk("wrap_data",  32'(if_std.rd_data), 32'(rv));
            chk("wrap_valid", 32'(if_std.rd_valid), 32'd1);
            rv++;
        end
        if_std.rd_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if_std.wr_data = 8'(wv);
            wv++;
            step();
        end
        chk("refill_full", 32'(if_std.full), 32'd1);

        // Full with read and write together: read wins, write rejected
        if_std.wr_en   = 1'b1;
        if_std.rd_en   = 1'b1;
        if_std.wr_data = 8'hEE;
        step();
        chk("fullrw_data",  32'(if_std.rd_data), 32'(rv));
        chk("fullrw_count", 32'(if_std.count), 32'd31);
        chk("fullrw_ovf",   32'(if_std.overflow), 32'd1);
        chk("fullrw_full",  32'(if_std.full), 32'd0);
        if_std.wr_en = 1'b0;

        // Mid-operation reset with count=10
        for (int k = 0; k < 21; k++) begin
            step();
        end
        chk("pre_rst_count", 32'(if_std.count), 32'd10);
        rst          = 1'b1;
        if_std.wr_en = 1'b1;
        step();
        chk("mrst_count", 32'(if_std.count), 32'd0);
        chk("mrst_empty", 32'(if_std.empty), 32'd1);
        chk("mrst_ae",    32'(if_std.almost_empty), 32'd1);
        chk("mrst_af",    32'(if_std.almost_full), 32'd0);
        chk("mrst_ovf",   32'(if_std.overflow), 32'd0);
        chk("mrst_data",  32'(if_std.rd_data), 32'd0);
        chk("mrst_valid", 32'(if_std.rd_valid), 32'd0);
        rst            = 1'b0;
        if_std.wr_en   = 1'b0;
        if_std.rd_en   = 1'b1;
        if_std.clr_err = 1'b1;
        step();
        chk("clr_vs_set", 32'(if_std.underflow), 32'd1);
        chk("post_rst_count", 32'(if_std.count), 32'd0);
        if_std.rd_en = 1'b0;
        step();
        chk("clr_after", 32'(if_std.underflow), 32'd0);
        if_std.clr_err = 1'b0;

        // FWFT: write into empty, head appears one edge later
        if_fwft.wr_en   = 1'b1;
        if_fwft.wr_data = 8'hA5;
        step();
        chk("fwft_n_empty", 32'(if_fwft.empty), 32'd1);
        chk("fwft_n_count", 32'(if_fwft.count), 32'd1);
        if_fwft.wr_en = 1'b0;
        step();
        chk("fwft_n1_empty", 32'(if_fwft.empty), 32'd0);
        chk("fwft_n1_data",  32'(if_fwft.rd_data), 32'hA5);
        chk("fwft_n1_valid", 32'(if_fwft.rd_valid), 32'd1);
        if_fwft.rd_en = 1'b1;
        step();
        chk("fwft_pop_empty", 32'(if_fwft.empty), 32'd1);
        chk("fwft_pop_count", 32'(if_fwft.count), 32'd0);
        if_fwft.rd_en = 1'b0;

        // FWFT: four words, four back-to-back pops
        for (int k = 0; k < 4; k++) begin
            if_fwft.wr_en   = 1'b1;
            if_fwft.wr_data = 8'((k + 1) * 8'h11);
            step();
        end
        if_fwft.wr_en = 1'b0;
        chk("fwft_head",  32'(if_fwft.rd_data), 32'h11);
        chk("fwft_cnt4",  32'(if_fwft.count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if_fwft.rd_en = 1'b1;
            step();
            chk("fwft_b2b_count", 32'(if_fwft.count), 32'(3 - k));
            chk("fwft_b2b_empty", 32'(if_fwft.empty), 32'(k == 3));
            chk("fwft_b2b_valid", 32'(if_fwft.rd_valid), 32'(k != 3));
            if (k < 3) begin
                chk("fwft_b2b_data", 32'(if_fwft.rd_data), 32'((k + 2) * 8'h11));
            end
        end
        step();
        chk("fwft_unf", 32'(if_fwft.underflow), 32'd1);
        if_fwft.rd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
